// File: rtl/csa_bec_pipe_acc.sv
// Two-stage add/sub/accumulate pipeline built on a square-root carry-select adder
// with BEC (+1) segment copies; accumulate results saturate to WIDTH+1 signed.
module csa_bec_pipe_acc #(
    parameter int WIDTH     = 16,
    parameter int FIRST_SEG = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic           in_sub,
    input  logic           in_acc,
    input  logic           in_clr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIDTH:0] out_sum,
    output logic           out_ovf
);
    localparam int W1 = WIDTH + 1;

    function automatic int seg_lo(input int idx);
        int lo;
        lo = 0;
        for (int k = 0; k < idx; k++) lo += FIRST_SEG + k;
        return lo;
    endfunction

    function automatic int seg_count();
        int n;
        int lo;
        n  = 0;
        lo = 0;
        while (lo < W1) begin
            lo += FIRST_SEG + n;
            n++;
        end
        return n;
    endfunction

    localparam int NSEG = seg_count();
    localparam logic [W1-1:0] SAT_MAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [W1-1:0] SAT_MIN = {1'b1, {WIDTH{1'b0}}};

    logic          en;
    logic [W1-1:0] a_ext;
    logic [W1-1:0] b_ext;
    logic [W1-1:0] x_sel;

    logic          s1_valid;
    logic [W1-1:0] s1_a;
    logic [W1-1:0] s1_x;
    logic          s1_cin;
    logic          s1_acc;
    logic          s1_clr;

    logic [W1-1:0] acc;
    logic [W1-1:0] add_a;
    logic [W1-1:0] add_b;
    logic [W1-1:0] add_s;
    logic [NSEG:0] seg_c;
    logic          guard;
    logic          ovf_raw;
    logic [W1-1:0] res;
    logic          res_ovf;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    assign a_ext = {in_a[WIDTH-1], in_a};
    assign b_ext = {in_b[WIDTH-1], in_b};
    assign x_sel = in_acc ? a_ext : b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_x     <= '0;
            s1_cin   <= 1'b0;
            s1_acc   <= 1'b0;
            s1_clr   <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_a     <= a_ext;
            s1_x     <= in_sub ? ~x_sel : x_sel;
            s1_cin   <= in_sub;
            s1_acc   <= in_acc;
            s1_clr   <= in_clr & in_acc;
        end
    end

    // Clear-load adds the conditioned operand to zero, giving +A or -A.
    assign add_a    = s1_acc ? (s1_clr ? '0 : acc) : s1_a;
    assign add_b    = s1_x;
    assign seg_c[0] = s1_cin;

    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        localparam int LO = seg_lo(i);
        localparam int HI = (seg_lo(i + 1) < W1) ? seg_lo(i + 1) : W1;
        localparam int SW = HI - LO;

        logic [SW-1:0] sa;
        logic [SW-1:0] sb;
        logic [SW-1:0] s0;
        logic [SW:0]   c0;

        assign sa = add_a[HI-1:LO];
        assign sb = add_b[HI-1:LO];

        for (genvar j = 0; j < SW; j++) begin : g_bit
            assign s0[j]     = sa[j] ^ sb[j] ^ c0[j];
            assign c0[j + 1] = (sa[j] & sb[j]) | (c0[j] & (sa[j] ^ sb[j]));
        end

        if (i == 0) begin : g_lsb
            assign c0[0]           = seg_c[0];
            assign add_s[HI-1:LO]  = s0;
            assign seg_c[1]        = c0[SW];
        end else begin : g_sel
            logic [SW-1:0] s1;
            logic [SW:0]   t;

            assign c0[0] = 1'b0;
            assign t[0]  = 1'b1;
            for (genvar j = 0; j < SW; j++) begin : g_bec
                assign s1[j]    = s0[j] ^ t[j];
                assign t[j + 1] = t[j] & s0[j];
            end
            assign add_s[HI-1:LO] = seg_c[i] ? s1 : s0;
            assign seg_c[i + 1]   = seg_c[i] ? (c0[SW] | t[SW]) : c0[SW];
        end
    end

    // Guard bit is the true sign of the WIDTH+2-bit sum.
    assign guard   = add_a[W1-1] ^ add_b[W1-1] ^ seg_c[NSEG];
    assign ovf_raw = guard ^ add_s[W1-1];

    always_comb begin
        res     = add_s;
        res_ovf = 1'b0;
        if (s1_acc && !s1_clr && ovf_raw) begin
            res_ovf = 1'b1;
            res     = guard ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            acc       <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum <= res;
                out_ovf <= res_ovf;
                if (s1_acc) acc <= res;
            end
        end
    end
endmodule

// File: tb/tb_csa_bec_pipe_acc.sv
// Bench for csa_bec_pipe_acc: directed literal cases plus random traffic with
// backpressure, checked against an arithmetic model with an ordered result queue.
module tb_csa_bec_pipe_acc;
    localparam int W = 16;
    localparam longint MAXV = (longint'(1) << W) - 1;
    localparam longint MINV = -(longint'(1) << W);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         in_acc = 1'b0;
    logic         in_clr = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W:0]   out_sum;
    logic         out_ovf;

    csa_bec_pipe_acc #(.WIDTH(W), .FIRST_SEG(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc), .in_clr(in_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sum;
        bit     ovf;
    } exp_t;

    exp_t   q[$];
    longint macc = 0;
    int     n_assert = 0;
    int     n_fail = 0;
    bit     phase_done;

    task automatic check(input string name, input longint act, input longint exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input longint a, input longint b,
                                   input bit sub, input bit acc_op, input bit clr);
        exp_t   e;
        longint r;
        e.ovf = 1'b0;
        if (!acc_op) begin
            r = sub ? a - b : a + b;
        end else if (clr) begin
            r = sub ? -a : a;
            macc = r;
        end else begin
            r = sub ? macc - a : macc + a;
            if (r > MAXV) begin r = MAXV; e.ovf = 1'b1; end
            else if (r < MINV) begin r = MINV; e.ovf = 1'b1; end
            macc = r;
        end
        e.sum = r;
        return e;
    endfunction

    // Scoreboard: outputs are stable mid-cycle, so compare on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            macc = 0;
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL sb_unexpected: out_valid with no beat pending, out_sum=%0d", $signed(out_sum));
                end else begin
                    check("sb_sum", $signed(out_sum), q[0].sum);
                    check("sb_ovf", out_ovf, q[0].ovf);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back(model($signed(in_a), $signed(in_b), in_sub, in_acc, in_clr));
        end
    end

    task automatic send_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input bit sub, input bit acc_op, input bit clr,
                              input longint exp_sum, input bit exp_ovf);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_a = a; in_b = b; in_sub = sub; in_acc = acc_op; in_clr = clr;
        in_valid = 1'b1;
        check({name, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        check({name, "_vld"}, out_valid, 1);
        check({name, "_sum"}, $signed(out_sum), exp_sum);
        check({name, "_ovf"}, out_ovf, exp_ovf);
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_assert++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles");
        end
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int t = 0; t < 30 && q.size() != 0; t++) @(posedge clk);
        @(posedge clk); #1;
        check(name, q.size(), 0);
    endtask

    function automatic logic [W-1:0] rand_val();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h8000;
            1: v = 16'h7FFF;
            2: v = 16'h0000;
            3: v = 16'hFFFF;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_sum", $signed(out_sum), 0);
        check("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;

        send_check("add_neg", -16'sd100, 16'sd37, 0, 0, 0, -63, 0);
        send_check("sub_min_b", 16'sd5, 16'h8000, 1, 0, 0, 32773, 0);
        send_check("sub_min_a", 16'h8000, 16'h7FFF, 1, 0, 0, -65535, 0);
        send_check("carry_all", 16'h7FFF, 16'h0001, 0, 0, 0, 32768, 0);
        send_check("carry_zero", 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0);

        send_check("acc_load", 16'd30000, 16'd0, 0, 1, 1, 30000, 0);
        send_check("acc_add1", 16'd30000, 16'd0, 0, 1, 0, 60000, 0);
        send_check("acc_sat", 16'd10000, 16'd0, 0, 1, 0, 65535, 1);
        send_check("acc_sat_hold", 16'hFFFF, 16'd0, 1, 1, 0, 65535, 1);
        send_check("acc_sub5", 16'd5, 16'd0, 1, 1, 0, 65530, 0);
        send_check("clr_no_acc", 16'd3, 16'd4, 0, 0, 1, 7, 0);
        send_check("acc_unchanged", 16'd0, 16'd0, 0, 1, 0, 65530, 0);
        send_check("acc_neg_min", 16'h8000, 16'd0, 1, 1, 1, 32768, 0);
        send_check("acc_ld_min", 16'h8000, 16'd0, 0, 1, 1, -32768, 0);
        send_check("acc_to_min", 16'h8000, 16'd0, 0, 1, 0, -65536, 0);
        send_check("acc_neg_sat", 16'hFFFF, 16'd0, 0, 1, 0, -65536, 1);

        // Backpressure with out_ready cycling 1,0,0.
        phase_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    in_a = rand_val(); in_b = rand_val();
                    in_sub = k[0]; in_acc = 1'b0; in_clr = 1'b0;
                    in_valid = 1'b1;
                    wait_accept();
                end
                in_valid = 1'b0;
                phase_done = 1'b1;
            end
            begin
                for (int c = 0; c < 60 && !phase_done; c++) begin
                    @(posedge clk); #1;
                    out_ready = ((c % 3) == 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // Reset with two beats in flight and ACC=1234.
        send_check("acc_1234", 16'd1234, 16'd0, 0, 1, 1, 1234, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_a = 16'd1; in_b = 16'd2; in_sub = 0; in_acc = 0; in_clr = 0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 16'd3; in_b = 16'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("inflight_vld", out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        rst = 1'b0;
        out_ready = 1'b1;
        send_check("acc_after_rst", 16'd7, 16'd0, 0, 1, 0, 7, 0);

        // Random traffic with random backpressure.
        phase_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    in_a = rand_val(); in_b = rand_val();
                    in_sub = 1'($urandom_range(0, 1));
                    in_acc = 1'($urandom_range(0, 1));
                    in_clr = ($urandom_range(0, 7) == 0);
                    in_valid = 1'b1;
                    wait_accept();
                end
                in_valid = 1'b0;
                phase_done = 1'b1;
            end
            begin
                while (!phase_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
